// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and multicycle EX hazards.
// Defining HAZARD_PERF_CNT_EN adds saturating stall/flush/load-use event counters.

module pipeline_hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 3,
   parameter int unsigned DIV_CYCLES = 8,
   parameter logic [31:0] NOP_IR     = 32'h6800_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] input_OF_IR,
   input  logic [31:0] input_EX_IR,
   input  logic [31:0] input_MA_IR,
   input  logic        is_branch_taken,
   output logic        pc_en,
   output logic        if_of_en,
   output logic        of_ex_en,
   output logic        if_of_flush,
   output logic        of_ex_bubble,
   output logic        ex_ma_bubble,
   output logic        alu_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events,
   output logic [31:0] loaduse_events
`endif
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00000,
      OP_SUB  = 5'b00001,
      OP_MUL  = 5'b00010,
      OP_DIV  = 5'b00011,
      OP_MOD  = 5'b00100,
      OP_CMP  = 5'b00101,
      OP_AND  = 5'b00110,
      OP_OR   = 5'b00111,
      OP_NOT  = 5'b01000,
      OP_MOV  = 5'b01001,
      OP_LSL  = 5'b01010,
      OP_LSR  = 5'b01011,
      OP_ASR  = 5'b01100,
      OP_NOP  = 5'b01101,
      OP_LD   = 5'b01110,
      OP_ST   = 5'b01111,
      OP_BEQ  = 5'b10000,
      OP_BGT  = 5'b10001,
      OP_B    = 5'b10010,
      OP_CALL = 5'b10011,
      OP_RET  = 5'b10100
   } opcode_e;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_e;

   localparam logic [3:0] RA_REG   = 4'hF;
   localparam logic [4:0] MUL_LOAD = (MUL_CYCLES >= 2) ? 5'(MUL_CYCLES - 2) : 5'd0;
   localparam logic [4:0] DIV_LOAD = (DIV_CYCLES >= 2) ? 5'(DIV_CYCLES - 2) : 5'd0;
   localparam logic       MUL_MC   = (MUL_CYCLES >= 2);
   localparam logic       DIV_MC   = (DIV_CYCLES >= 2);

   // Field decode of the OF and EX instructions.
   opcode_e    w_of_op;
   opcode_e    w_ex_op;
   logic       w_of_imm;
   logic [3:0] w_of_rd;
   logic [3:0] w_of_rs1;
   logic [3:0] w_of_rs2;
   logic [3:0] w_ex_rd;

   assign w_of_op  = opcode_e'(input_OF_IR[31:27]);
   assign w_of_imm = input_OF_IR[26];
   assign w_of_rd  = input_OF_IR[25:22];
   assign w_of_rs1 = input_OF_IR[21:18];
   assign w_of_rs2 = input_OF_IR[17:14];
   assign w_ex_op  = opcode_e'(input_EX_IR[31:27]);
   assign w_ex_rd  = input_EX_IR[25:22];

   // MA is not needed for these hazards and the controller never injects NOP_IR itself.
   logic w_unused;
   assign w_unused = ^{input_MA_IR, input_OF_IR[13:0], input_EX_IR[26], input_EX_IR[21:0], NOP_IR};

   logic       w_src1_vld;
   logic       w_src2_vld;
   logic [3:0] w_src1;
   logic [3:0] w_src2;

   // NOTE: every signal written in an always_comb gets a default first; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      w_src1_vld = 1'b0;
      w_src2_vld = 1'b0;
      w_src1     = w_of_rs1;
      w_src2     = w_of_rs2;
      case (w_of_op)
         OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL: begin
         end
         OP_RET: begin
            w_src1_vld = 1'b1;
            w_src1     = RA_REG;
         end
         OP_ST: begin
            w_src1_vld = 1'b1;
            w_src2_vld = 1'b1;
            w_src2     = w_of_rd;
         end
         OP_NOT, OP_MOV: begin
            w_src2_vld = ~w_of_imm;
         end
         default: begin
            w_src1_vld = 1'b1;
            w_src2_vld = ~w_of_imm;
         end
      endcase
   end

   logic w_loaduse;
   assign w_loaduse = (w_ex_op == OP_LD) &&
                      ((w_src1_vld && (w_src1 == w_ex_rd)) ||
                       (w_src2_vld && (w_src2 == w_ex_rd)));

   logic       w_ex_mul;
   logic       w_ex_div;
   logic       w_ex_multi;
   logic [4:0] w_ex_load;

   assign w_ex_mul   = (w_ex_op == OP_MUL);
   assign w_ex_div   = (w_ex_op == OP_DIV) || (w_ex_op == OP_MOD);
   assign w_ex_multi = (w_ex_mul && MUL_MC) || (w_ex_div && DIV_MC);
   assign w_ex_load  = w_ex_mul ? MUL_LOAD : DIV_LOAD;

   // Multicycle FSM: cnt counts the remaining stall cycles after the current one.
   state_e     r_state;
   state_e     w_state_nxt;
   logic [4:0] r_cnt;
   logic [4:0] w_cnt_nxt;
   logic       w_stall;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ex_multi) begin
               w_stall     = 1'b1;
               w_cnt_nxt   = w_ex_load;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt != 5'd0) begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt - 5'd1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Priority: multicycle stall, then branch flush, then load-use bubble.
   logic w_branch;
   logic w_lu_stall;

   assign w_branch   = is_branch_taken && !w_stall;
   assign w_lu_stall = w_loaduse && !is_branch_taken && !w_stall;

   always_comb begin
      pc_en        = 1'b1;
      if_of_en     = 1'b1;
      of_ex_en     = 1'b1;
      if_of_flush  = 1'b0;
      of_ex_bubble = 1'b0;
      ex_ma_bubble = 1'b0;
      alu_busy     = 1'b0;
      if (!reset) begin
         if (w_stall) begin
            pc_en        = 1'b0;
            if_of_en     = 1'b0;
            of_ex_en     = 1'b0;
            ex_ma_bubble = 1'b1;
            alu_busy     = 1'b1;
         end else if (w_branch) begin
            if_of_flush  = 1'b1;
            of_ex_bubble = 1'b1;
         end else if (w_lu_stall) begin
            pc_en        = 1'b0;
            if_of_en     = 1'b0;
            of_ex_bubble = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;
   logic [31:0] r_loaduse_events;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles   <= 32'd0;
         r_flush_events   <= 32'd0;
         r_loaduse_events <= 32'd0;
      end else begin
         if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (w_branch && (r_flush_events != 32'hFFFF_FFFF)) begin
            r_flush_events <= r_flush_events + 32'd1;
         end
         if (w_lu_stall && (r_loaduse_events != 32'hFFFF_FFFF)) begin
            r_loaduse_events <= r_loaduse_events + 32'd1;
         end
      end
   end

   assign stall_cycles   = r_stall_cycles;
   assign flush_events   = r_flush_events;
   assign loaduse_events = r_loaduse_events;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus a random instruction stream
// flowing through a small pipeline model that obeys the expected enables.

module tb_pipeline_hazard_ctrl;

   localparam int          MUL_N = 3;
   localparam int          DIV_N = 8;
   localparam logic [31:0] NOP   = 32'h6800_0000;

   // {pc_en, if_of_en, of_ex_en, if_of_flush, of_ex_bubble, ex_ma_bubble, alu_busy}
   localparam logic [6:0] O_DEF   = 7'b1110000;
   localparam logic [6:0] O_STALL = 7'b0000011;
   localparam logic [6:0] O_BR    = 7'b1111100;
   localparam logic [6:0] O_LU    = 7'b0010100;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] of_ir;
   logic [31:0] ex_ir;
   logic [31:0] ma_ir;
   logic        taken;
   logic        pc_en;
   logic        if_of_en;
   logic        of_ex_en;
   logic        if_of_flush;
   logic        of_ex_bubble;
   logic        ex_ma_bubble;
   logic        alu_busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
   logic [31:0] loaduse_events;
`endif

   pipeline_hazard_ctrl #(
      .MUL_CYCLES(MUL_N),
      .DIV_CYCLES(DIV_N),
      .NOP_IR    (NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .input_OF_IR    (of_ir),
      .input_EX_IR    (ex_ir),
      .input_MA_IR    (ma_ir),
      .is_branch_taken(taken),
      .pc_en          (pc_en),
      .if_of_en       (if_of_en),
      .of_ex_en       (of_ex_en),
      .if_of_flush    (if_of_flush),
      .of_ex_bubble   (of_ex_bubble),
      .ex_ma_bubble   (ex_ma_bubble),
      .alu_busy       (alu_busy)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles   (stall_cycles),
      .flush_events   (flush_events),
      .loaduse_events (loaduse_events)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model pipeline registers and the number of cycles the EX occupant has spent in EX.
   logic [31:0] m_of;
   logic [31:0] m_ex;
   logic [31:0] m_ma;
   int          m_age;
   bit          m_force_br;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs1, input logic [3:0] rs2);
      return {op, 1'b0, rd, rs1, rs2, 14'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs1, input logic [17:0] imm);
      return {op, 1'b1, rd, rs1, imm};
   endfunction

   function automatic int latency(input logic [31:0] ir);
      case (ir[31:27])
         5'b00010:          return MUL_N;
         5'b00011, 5'b00100: return DIV_N;
         default:           return 1;
      endcase
   endfunction

   // Does the instruction read register r as a source operand?
   function automatic bit reads_reg(input logic [31:0] ir, input logic [3:0] r);
      logic [3:0] rd;
      logic [3:0] rs1;
      logic [3:0] rs2;
      bit         reg_form;
      rd       = ir[25:22];
      rs1      = ir[21:18];
      rs2      = ir[17:14];
      reg_form = (ir[26] == 1'b0);
      case (ir[31:27])
         5'b01101, 5'b10000, 5'b10001, 5'b10010, 5'b10011: return 1'b0;
         5'b10100: return (r == 4'hF);
         5'b01111: return (r == rs1) || (r == rd);
         5'b01000, 5'b01001: return reg_form && (r == rs2);
         default:  return (r == rs1) || (reg_form && (r == rs2));
      endcase
   endfunction

   function automatic logic [6:0] model_out(input logic rst, input logic tk,
                                            input logic [31:0] of, input logic [31:0] ex,
                                            input int age);
      int n;
      bit stall;
      bit lu;
      n     = latency(ex);
      stall = (n > 1) && (age < n - 1);
      lu    = (ex[31:27] == 5'b01110) && reads_reg(of, ex[25:22]);
      if (rst)   return O_DEF;
      if (stall) return O_STALL;
      if (tk)    return O_BR;
      if (lu)    return O_LU;
      return O_DEF;
   endfunction

   function automatic logic [31:0] rand_ir();
      logic [4:0] op;
      logic [3:0] rd;
      op = 5'($urandom_range(0, 20));
      rd = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      return {op, 1'($urandom_range(0, 1)), rd, 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 14'($urandom)};
   endfunction

   // One pipeline cycle: drive, check at negedge, then advance the model on the edge.
   task automatic step(output logic [6:0] o);
      logic [6:0] e;
      logic       tk;
      logic [4:0] eop;
      eop = m_ex[31:27];
      tk  = m_force_br || (eop == 5'b10010) || (eop == 5'b10011) || (eop == 5'b10100) ||
            (((eop == 5'b10000) || (eop == 5'b10001)) && ($urandom_range(0, 1) == 1));
      of_ir = m_of;
      ex_ir = m_ex;
      ma_ir = m_ma;
      taken = tk;
      e = model_out(reset, tk, m_of, m_ex, m_age);
      @(negedge clk);
      o = {pc_en, if_of_en, of_ex_en, if_of_flush, of_ex_bubble, ex_ma_bubble, alu_busy};
      check("outputs_vs_model", 32'(o), 32'(e));
      @(posedge clk);
      if (reset) begin
         m_age = 0;
      end else if (e[0]) begin
         m_ma  = NOP;
         m_age = m_age + 1;
      end else begin
         m_ma  = m_ex;
         m_ex  = e[2] ? NOP : m_of;
         m_age = 0;
         m_of  = e[3] ? NOP : (e[5] ? rand_ir() : m_of);
      end
      m_force_br = 1'b0;
      #1;
   endtask

   initial begin
      logic [6:0]  o;
      logic [10:0] pattern;
      int          busy;
`ifdef HAZARD_PERF_CNT_EN
      logic [31:0] lu_before;
`endif
      reset = 1'b1;
      of_ir = NOP;
      ex_ir = NOP;
      ma_ir = NOP;
      taken = 1'b0;
      m_of = NOP;
      m_ex = NOP;
      m_ma = NOP;
      m_age = 0;
      m_force_br = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state: a div in EX must not stall while reset is high.
      m_ex = enc_r(5'b00011, 4'd1, 4'd2, 4'd3);
      step(o);
      check("reset_default", 32'(o), 32'(O_DEF));
      reset = 1'b0;

      // Load-use: ld r3,[r1+4] in EX, add r5,r3,r2 in OF.
      m_ex = enc_i(5'b01110, 4'd3, 4'd1, 18'd4);
      m_of = enc_r(5'b00000, 4'd5, 4'd3, 4'd2);
      m_age = 0;
      step(o);
      check("ld_use_stall", 32'(o), 32'(O_LU));
      step(o);
      check("ld_use_release", 32'(o), 32'(O_DEF));

      m_ex = enc_i(5'b01110, 4'd3, 4'd1, 18'd4);
      m_of = enc_i(5'b00000, 4'd5, 4'd4, 18'd3);
      m_age = 0;
      step(o);
      check("ld_no_dep", 32'(o), 32'(O_DEF));

      // st reads rd; mov does not read rs1.
      m_ex = enc_i(5'b01110, 4'd2, 4'd1, 18'd0);
      m_of = enc_i(5'b01111, 4'd2, 4'd1, 18'd8);
      m_age = 0;
      step(o);
      check("st_reads_rd", 32'(o), 32'(O_LU));
      m_ex = enc_i(5'b01110, 4'd3, 4'd1, 18'd0);
      m_of = enc_i(5'b01001, 4'd5, 4'd3, 18'd7);
      m_age = 0;
      step(o);
      check("mov_ignores_rs1", 32'(o), 32'(O_DEF));

      // Taken branch, then branch winning over a simultaneous load-use.
      m_ex = enc_r(5'b10000, 4'd0, 4'd0, 4'd0);
      m_of = enc_r(5'b00000, 4'd5, 4'd3, 4'd2);
      m_age = 0;
      m_force_br = 1'b1;
      step(o);
      check("branch_flush", 32'(o), 32'(O_BR));
      step(o);
      check("branch_after", 32'(o), 32'(O_DEF));
      m_ex = enc_i(5'b01110, 4'd3, 4'd1, 18'd4);
      m_of = enc_r(5'b00000, 4'd5, 4'd3, 4'd2);
      m_age = 0;
      m_force_br = 1'b1;
      step(o);
      check("branch_over_ld", 32'(o), 32'(O_BR));

      // Divide: 7 stall cycles, release on the 8th.
      m_ex = enc_r(5'b00011, 4'd1, 4'd2, 4'd3);
      m_of = enc_i(5'b00000, 4'd5, 4'd4, 18'd3);
      m_age = 0;
      busy = 0;
      for (int i = 0; i < 8; i++) begin
         step(o);
         busy += int'(o[0]);
         if (i < 7) check("div_stall", 32'(o), 32'(O_STALL));
         else       check("div_release", 32'(o), 32'(O_DEF));
      end
      check("div_busy_cycles", 32'(busy), 32'd7);

      // Multiply: 2 stall cycles.
      m_ex = enc_r(5'b00010, 4'd1, 4'd2, 4'd3);
      m_of = enc_i(5'b00000, 4'd5, 4'd4, 18'd3);
      m_age = 0;
      busy = 0;
      for (int i = 0; i < 3; i++) begin
         step(o);
         busy += int'(o[0]);
      end
      check("mul_busy_cycles", 32'(busy), 32'd2);

      // Back-to-back mul then div: S S R S S S S S S S R.
      m_ex = enc_r(5'b00010, 4'd1, 4'd2, 4'd3);
      m_of = enc_r(5'b00011, 4'd6, 4'd2, 4'd3);
      m_age = 0;
      pattern = '0;
      for (int i = 0; i < 11; i++) begin
         step(o);
         pattern[i] = o[0];
      end
      check("b2b_pattern", 32'(pattern), 32'(11'b01111111011));

      // Reset in the middle of a div, when cnt has counted down to 4.
      m_ex = enc_r(5'b00011, 4'd1, 4'd2, 4'd3);
      m_of = enc_i(5'b00000, 4'd5, 4'd4, 18'd3);
      m_age = 0;
      repeat (3) step(o);
      reset = 1'b1;
      step(o);
      check("reset_mid_busy", 32'(o), 32'(O_DEF));
      reset = 1'b0;
      m_ex = enc_i(5'b00000, 4'd5, 4'd4, 18'd3);
      m_of = enc_i(5'b00000, 4'd6, 4'd4, 18'd1);
      m_age = 0;
      step(o);
      check("after_reset", 32'(o), 32'(O_DEF));

      // ret reads r15.
`ifdef HAZARD_PERF_CNT_EN
      lu_before = loaduse_events;
`endif
      m_ex = enc_i(5'b01110, 4'hF, 4'd1, 18'd0);
      m_of = {5'b10100, 27'd0};
      m_age = 0;
      step(o);
      check("ret_ld_use", 32'(o), 32'(O_LU));
`ifdef HAZARD_PERF_CNT_EN
      check("loaduse_events", loaduse_events, lu_before + 32'd1);
`endif
      m_ex = enc_i(5'b01110, 4'hE, 4'd1, 18'd0);
      m_of = {5'b10100, 27'd0};
      m_age = 0;
      step(o);
      check("ret_no_dep", 32'(o), 32'(O_DEF));

      // Random instruction stream with occasional resets.
      for (int k = 0; k < 3000; k++) begin
         reset = ($urandom_range(0, 299) == 0);
         step(o);
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
